// File: rtl/s298_bist_ctrl.sv
// rtl/s298_bist_ctrl.sv - BIST controller driving s298 from an LFSR and compacting its outputs in a MISR
module s298_bist_ctrl #(
    parameter int          NUM_PATTERNS = 255,
    parameter int          FLUSH_CYCLES = 4,
    parameter logic [7:0]  LFSR_SEED    = 8'h01,
    parameter logic [15:0] GOLDEN_SIG   = 16'h0000
) (
    input  logic        CK,
    input  logic        RST,
    input  logic        START,
    output logic        G0,
    output logic        G1,
    output logic        G2,
    input  logic        G66,
    input  logic        G67,
    input  logic        G117,
    input  logic        G118,
    input  logic        G132,
    input  logic        G133,
    output logic        BUSY,
    output logic        DONE,
    output logic        PASS,
    output logic [15:0] SIG,
    output logic [15:0] PAT_CNT
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FLUSH = 3'd1,
        S_APPLY = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // An all-zero LFSR would lock up, so a zero seed falls back to 8'h01.
    localparam logic [7:0]  SEED       = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [15:0] PAT_MAX    = 16'(NUM_PATTERNS);
    localparam logic [15:0] PAT_LAST   = 16'(NUM_PATTERNS - 1);
    localparam logic [15:0] FLUSH_LAST = 16'(FLUSH_CYCLES - 1);

    state_t      state;
    logic [7:0]  lfsr;
    logic [7:0]  lfsr_next;
    logic [15:0] flush_cnt;
    logic [15:0] misr_shift;
    logic [15:0] misr_next;
    logic        fb;

    // Next LFSR pattern (x^8+x^6+x^5+x^4+1) and next MISR value from the CUT response.
    always_comb begin
        lfsr_next      = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        fb             = SIG[15];
        misr_shift     = {SIG[14:0], fb};
        misr_shift[12] = SIG[11] ^ fb;
        misr_shift[5]  = SIG[4] ^ fb;
        misr_next      = misr_shift ^ {10'b0, G133, G132, G118, G117, G67, G66};
    end

    // Test sequencer; every output is a register loaded with the value for the state being entered.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state     <= S_IDLE;
            lfsr      <= SEED;
            flush_cnt <= 16'd0;
            SIG       <= 16'd0;
            PAT_CNT   <= 16'd0;
            G0        <= 1'b0;
            G1        <= 1'b0;
            G2        <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            PASS      <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (START) begin
                        state     <= S_FLUSH;
                        lfsr      <= SEED;
                        flush_cnt <= 16'd0;
                        SIG       <= 16'd0;
                        PAT_CNT   <= 16'd0;
                        G0        <= 1'b1;
                        G1        <= 1'b0;
                        G2        <= 1'b0;
                        BUSY      <= 1'b1;
                        DONE      <= 1'b0;
                        PASS      <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    if (flush_cnt == FLUSH_LAST) begin
                        state <= S_APPLY;
                        G0    <= lfsr[0];
                        G1    <= lfsr[1];
                        G2    <= lfsr[2];
                    end else begin
                        flush_cnt <= flush_cnt + 16'd1;
                    end
                end
                S_APPLY: begin
                    // The CUT response lags its pattern by one cycle, so the first APPLY cycle carries
                    // no response yet; the last response is picked up in DRAIN instead.
                    if (PAT_CNT != 16'd0) begin
                        SIG <= misr_next;
                    end
                    if (PAT_CNT < PAT_MAX) begin
                        PAT_CNT <= PAT_CNT + 16'd1;
                    end
                    lfsr <= lfsr_next;
                    if (PAT_CNT >= PAT_LAST) begin
                        state <= S_DRAIN;
                        G0    <= 1'b0;
                        G1    <= 1'b0;
                        G2    <= 1'b0;
                    end else begin
                        G0 <= lfsr_next[0];
                        G1 <= lfsr_next[1];
                        G2 <= lfsr_next[2];
                    end
                end
                S_DRAIN: begin
                    state <= S_DONE;
                    SIG   <= misr_next;
                    PASS  <= (misr_next == GOLDEN_SIG);
                    BUSY  <= 1'b0;
                    DONE  <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_s298_bist_ctrl.sv
// tb/tb_s298_bist_ctrl.sv - self-checking bench for s298_bist_ctrl with a behavioural signature model
module tb_s298_bist_ctrl;

    logic        CK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic        START1 = 1'b0;
    logic        G0, G1, G2, BUSY, DONE, PASS;
    logic [15:0] SIG, PAT_CNT;
    logic        H0, H1, H2, BUSY1, DONE1, PASS1;
    logic [15:0] SIG1, PAT_CNT1;

    logic [5:0]  cut_st;
    logic [5:0]  cut_st1;
    logic [5:0]  resp;
    logic [5:0]  key = 6'h00;
    int          resp_mode = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 CK = ~CK;

    // Stand-in sequential CUT: registered outputs, forced to a known state by pattern 001.
    function automatic logic [5:0] cut_next(input logic [5:0] st, input logic [2:0] g, input logic [5:0] k);
        if (g == 3'b001) return 6'h2A;
        return {st[4:0], st[5] ^ g[2]} ^ {3'b000, g} ^ (g[1] ? k : 6'h00);
    endfunction

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], ^(l & 8'hB8)};
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [5:0] r);
        return ((s << 1) ^ (s[15] ? 16'h1021 : 16'h0000)) ^ {10'b0, r};
    endfunction

    // Signature after n patterns: response j is the CUT state after absorbing pattern j.
    function automatic logic [15:0] model_sig(input int n, input int mode, input logic [5:0] k);
        logic [7:0]  l;
        logic [5:0]  st;
        logic [5:0]  r;
        logic [15:0] s;
        l  = 8'h01;
        st = 6'h2A;
        s  = 16'h0000;
        for (int j = 0; j < n; j++) begin
            st = cut_next(st, l[2:0], k);
            r  = (mode == 0) ? 6'h00 : (mode == 1) ? 6'h01 : st;
            s  = misr_step(s, r);
            l  = lfsr_step(l);
        end
        return s;
    endfunction

    always @(posedge CK or posedge RST) begin
        if (RST) begin
            cut_st  <= 6'h00;
            cut_st1 <= 6'h00;
        end else begin
            cut_st  <= cut_next(cut_st, {G2, G1, G0}, key);
            cut_st1 <= cut_next(cut_st1, {H2, H1, H0}, key);
        end
    end

    assign resp = (resp_mode == 0) ? 6'h00 : (resp_mode == 1) ? 6'h01 : cut_st;

    s298_bist_ctrl dut (
        .CK(CK), .RST(RST), .START(START),
        .G0(G0), .G1(G1), .G2(G2),
        .G66(resp[0]), .G67(resp[1]), .G117(resp[2]), .G118(resp[3]), .G132(resp[4]), .G133(resp[5]),
        .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .SIG(SIG), .PAT_CNT(PAT_CNT)
    );

    s298_bist_ctrl #(.NUM_PATTERNS(1)) dut1 (
        .CK(CK), .RST(RST), .START(START1),
        .G0(H0), .G1(H1), .G2(H2),
        .G66(cut_st1[0]), .G67(cut_st1[1]), .G117(cut_st1[2]), .G118(cut_st1[3]),
        .G132(cut_st1[4]), .G133(cut_st1[5]),
        .BUSY(BUSY1), .DONE(DONE1), .PASS(PASS1), .SIG(SIG1), .PAT_CNT(PAT_CNT1)
    );

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    task automatic idle_gap();
        repeat ($urandom_range(0, 5)) step();
    endtask

    // Pulses START and counts further edges until DONE rises (bounded).
    task automatic do_run(output int edges);
        START = 1'b1;
        step();
        START = 1'b0;
        edges = 0;
        while (DONE !== 1'b1 && edges < 1000) begin
            step();
            edges++;
        end
    endtask

    task automatic test_reset();
        step();
        checks++; if ({G2, G1, G0} !== 3'b000) begin errors++; $display("FAIL reset_g: got %b expected 000", {G2, G1, G0}); end
        checks++; if (SIG !== 16'h0000) begin errors++; $display("FAIL reset_sig: got %h expected 0000", SIG); end
        checks++; if (PAT_CNT !== 16'h0000) begin errors++; $display("FAIL reset_patcnt: got %0d expected 0", PAT_CNT); end
        checks++; if ({BUSY, DONE, PASS} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {BUSY, DONE, PASS}); end
        RST = 1'b0;
        step();
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b expected 0", BUSY); end
    endtask

    task automatic test_sequence();
        logic [7:0] l;
        resp_mode = 0;
        idle_gap();
        START = 1'b1;
        step();
        START = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if ({G2, G1, G0, BUSY} !== 4'b0011) begin errors++; $display("FAIL flush_g_busy[%0d]: got %b expected 0011", i, {G2, G1, G0, BUSY}); end
            step();
        end
        l = 8'h01;
        for (int i = 0; i < 6; i++) begin
            checks++; if ({G2, G1, G0} !== l[2:0]) begin errors++; $display("FAIL apply_g[%0d]: got %b expected %b", i, {G2, G1, G0}, l[2:0]); end
            checks++; if (PAT_CNT !== 16'(i)) begin errors++; $display("FAIL apply_patcnt[%0d]: got %0d expected %0d", i, PAT_CNT, i); end
            l = lfsr_step(l);
            step();
        end
        for (int i = 0; i < 1000 && DONE !== 1'b1; i++) step();
    endtask

    task automatic test_zero_cut();
        int edges;
        resp_mode = 0;
        idle_gap();
        do_run(edges);
        checks++; if (edges != 260) begin errors++; $display("FAIL zero_run_len: got %0d expected 260", edges); end
        checks++; if (SIG !== model_sig(255, 0, key)) begin errors++; $display("FAIL zero_sig: got %h expected %h", SIG, model_sig(255, 0, key)); end
        checks++; if (PASS !== 1'b1) begin errors++; $display("FAIL zero_pass: got %b expected 1", PASS); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b expected 0", BUSY); end
        repeat (5) step();
        checks++; if (PAT_CNT !== 16'd255) begin errors++; $display("FAIL zero_patcnt_hold: got %0d expected 255", PAT_CNT); end
        checks++; if (DONE !== 1'b1) begin errors++; $display("FAIL zero_done_hold: got %b expected 1", DONE); end
    endtask

    task automatic test_stuck();
        logic [15:0] exp;
        resp_mode = 1;
        exp = model_sig(255, 1, key);
        START = 1'b1;
        step();
        START = 1'b0;
        checks++; if ({DONE, PASS} !== 2'b00) begin errors++; $display("FAIL restart_done_pass: got %b expected 00", {DONE, PASS}); end
        repeat (4) step();
        checks++; if (SIG !== 16'h0000) begin errors++; $display("FAIL stuck_sig_apply1: got %h expected 0000", SIG); end
        step();
        checks++; if (SIG !== 16'h0000) begin errors++; $display("FAIL stuck_sig_apply2: got %h expected 0000", SIG); end
        step();
        checks++; if (SIG !== 16'h0001) begin errors++; $display("FAIL stuck_first_update: got %h expected 0001", SIG); end
        for (int i = 0; i < 1000 && DONE !== 1'b1; i++) step();
        checks++; if (SIG !== exp) begin errors++; $display("FAIL stuck_sig: got %h expected %h", SIG, exp); end
        checks++; if (PASS !== (exp == 16'h0000)) begin errors++; $display("FAIL stuck_pass: got %b expected %b", PASS, (exp == 16'h0000)); end
    endtask

    logic [15:0] first_sig;

    task automatic test_start_during_apply();
        int edges;
        int k;
        logic [15:0] exp;
        resp_mode = 2;
        key = 6'($urandom);
        exp = model_sig(255, 2, key);
        k = $urandom_range(5, 200);
        idle_gap();
        START = 1'b1;
        step();
        START = 1'b0;
        edges = 0;
        while (DONE !== 1'b1 && edges < 1000) begin
            START = (edges == k);
            step();
            edges++;
        end
        START = 1'b0;
        checks++; if (edges != 260) begin errors++; $display("FAIL apply_start_run_len: got %0d expected 260 (pulse at %0d)", edges, k); end
        checks++; if (PAT_CNT !== 16'd255) begin errors++; $display("FAIL apply_start_patcnt: got %0d expected 255", PAT_CNT); end
        checks++; if (SIG !== exp) begin errors++; $display("FAIL apply_start_sig: got %h expected %h key %h", SIG, exp, key); end
        checks++; if (PASS !== (exp == 16'h0000)) begin errors++; $display("FAIL apply_start_pass: got %b expected %b", PASS, (exp == 16'h0000)); end
        first_sig = exp;
    endtask

    task automatic test_back_to_back();
        int edges;
        START = 1'b1;
        step();
        START = 1'b0;
        checks++; if ({BUSY, DONE, PASS} !== 3'b100) begin errors++; $display("FAIL b2b_flags: got %b expected 100", {BUSY, DONE, PASS}); end
        checks++; if ({SIG, PAT_CNT} !== 32'h0) begin errors++; $display("FAIL b2b_clear: got %h/%0d expected 0000/0", SIG, PAT_CNT); end
        edges = 0;
        while (DONE !== 1'b1 && edges < 1000) begin
            step();
            edges++;
        end
        checks++; if (edges != 260) begin errors++; $display("FAIL b2b_run_len: got %0d expected 260", edges); end
        checks++; if (SIG !== first_sig) begin errors++; $display("FAIL b2b_sig: got %h expected %h", SIG, first_sig); end
    endtask

    task automatic test_reset_mid_apply();
        int n;
        resp_mode = 2;
        START = 1'b1;
        step();
        START = 1'b0;
        n = 0;
        while (PAT_CNT !== 16'd10 && n < 100) begin
            step();
            n++;
        end
        checks++; if (PAT_CNT !== 16'd10) begin errors++; $display("FAIL rst_reach_pat10: got %0d expected 10", PAT_CNT); end
        RST = 1'b1;
        #1;
        checks++; if ({SIG, PAT_CNT} !== 32'h0) begin errors++; $display("FAIL rst_mid_clear: got %h/%0d expected 0000/0", SIG, PAT_CNT); end
        checks++; if ({BUSY, G2, G1, G0} !== 4'b0000) begin errors++; $display("FAIL rst_mid_outs: got %b expected 0000", {BUSY, G2, G1, G0}); end
        step();
        RST = 1'b0;
        repeat (20) step();
        checks++; if ({BUSY, DONE, PAT_CNT} !== 18'h0) begin errors++; $display("FAIL rst_no_resume: got busy %b done %b pat %0d expected 0 0 0", BUSY, DONE, PAT_CNT); end
        RST = 1'b1;
        START = 1'b1;
        step();
        RST = 1'b0;
        START = 1'b0;
        step();
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rst_beats_start: got %b expected 0", BUSY); end
    endtask

    task automatic test_single_pattern();
        int edges;
        logic [15:0] exp;
        key = 6'($urandom);
        exp = model_sig(1, 2, key);
        idle_gap();
        START1 = 1'b1;
        step();
        START1 = 1'b0;
        edges = 0;
        while (DONE1 !== 1'b1 && edges < 100) begin
            if (edges == 5) begin
                checks++; if (SIG1 !== 16'h0000) begin errors++; $display("FAIL single_sig_drain: got %h expected 0000", SIG1); end
            end
            step();
            edges++;
        end
        checks++; if (edges != 6) begin errors++; $display("FAIL single_run_len: got %0d expected 6", edges); end
        checks++; if (SIG1 !== exp) begin errors++; $display("FAIL single_sig: got %h expected %h", SIG1, exp); end
        checks++; if (PAT_CNT1 !== 16'd1) begin errors++; $display("FAIL single_patcnt: got %0d expected 1", PAT_CNT1); end
        checks++; if (PASS1 !== (exp == 16'h0000)) begin errors++; $display("FAIL single_pass: got %b expected %b", PASS1, (exp == 16'h0000)); end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_zero_cut();
        test_stuck();
        test_start_during_apply();
        test_back_to_back();
        test_reset_mid_apply();
        test_single_pattern();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
